parking_gate_ctrl: RTL and testbench

//  Multi-slot car-park entry controller; successor to the single-slot gate FSM.

---
 rtl/parking_pkg.sv | 53 +++++
 rtl/parking_occ_counter.sv | 38 +++
 rtl/parking_gate_ctrl.sv | 138 +++++++++++++
 tb/tb_parking_gate_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared types and glyphs for the car-park entry controller.
package parking_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_PASS = 3'd1,
    S_FULL      = 3'd2,
    S_GRANT     = 3'd3,
    S_STOP      = 3'd4,
    S_LOCKOUT   = 3'd5
  } state_e;

  // 7-seg glyphs, active-low, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_N     = 7'h2B;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_U     = 7'h41;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_P     = 7'h0C;
  localparam logic [6:0] SEG_L     = 7'h47;
  localparam logic [6:0] SEG_O     = 7'h23;

  // Everything the driver panel shows for one state
  typedef struct packed {
    logic       green;
    logic       red;
    logic       gate;
    logic [6:0] hex1;
    logic [6:0] hex2;
  } panel_t;

  localparam panel_t PANEL_OFF = '{green: 1'b0, red: 1'b0, gate: 1'b0,
                                   hex1: SEG_BLANK, hex2: SEG_BLANK};

  // Panel contents for a state; blink is the divider phase for flashing LEDs
  function automatic panel_t state_panel(input state_e s, input logic blink);
    panel_t p;
    p = PANEL_OFF;
    case (s)
      S_WAIT_PASS: begin p.red = 1'b1;  p.hex1 = SEG_E; p.hex2 = SEG_N; end
      S_FULL:      begin p.red = 1'b1;  p.hex1 = SEG_F; p.hex2 = SEG_U; end
      S_GRANT:     begin p.green = blink; p.gate = 1'b1; p.hex1 = SEG_6; p.hex2 = SEG_0; end
      S_STOP:      begin p.red = blink; p.gate = 1'b1; p.hex1 = SEG_5; p.hex2 = SEG_P; end
      S_LOCKOUT:   begin p.red = blink; p.hex1 = SEG_L; p.hex2 = SEG_O; end
      default:     ;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/parking_occ_counter.sv
// Saturating occupancy counter: +1 on park, -1 on depart, simultaneous events cancel.
module parking_occ_counter
  import parking_pkg::*;
#(
  parameter int CAPACITY = 8,
  parameter int CNT_W    = $clog2(CAPACITY + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o
);

  localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: never wraps past CAPACITY or below zero
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && cnt_q != CAP)
      cnt_d = cnt_q + 1'b1;
    else if (dec_i && !inc_i && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  // Count register, cleared by reset
  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;
  assign full_o  = (cnt_q == CAP);

endmodule

// File: rtl/parking_gate_ctrl.sv
// Multi-slot car-park entry controller: access-code FSM, retry lockout,
// entry timeout, occupancy tracking and registered panel outputs.
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int                CAPACITY    = 8,
  parameter int                PW_WIDTH    = 4,
  parameter logic [PW_WIDTH-1:0] PASS_CODE = 4'hA,
  parameter int                TIMEOUT     = 64,
  parameter int                MAX_TRIES   = 3,
  parameter int                LOCK_CYCLES = 256,
  parameter int                BLINK_LOG2  = 3,
  localparam int               CNT_W       = $clog2(CAPACITY + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                entry,
  input  logic                exit,
  input  logic                depart,
  input  logic                pass_valid,
  input  logic [PW_WIDTH-1:0] pass_code,
  output logic                GREEN,
  output logic                RED,
  output logic                gate_open,
  output logic [CNT_W-1:0]    occupancy,
  output logic                full,
  output logic [6:0]          HEX_1,
  output logic [6:0]          HEX_2
);

  localparam int TMR_MAX = (TIMEOUT > LOCK_CYCLES) ? TIMEOUT : LOCK_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int TRY_W   = $clog2(MAX_TRIES + 1);

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [TRY_W-1:0] tries_q, tries_d, tries_inc;
  logic [BLINK_LOG2-1:0] blink_q;
  panel_t           panel_q;
  logic             code_ok, code_bad, park_inc, timer_clr;

  assign code_ok   = pass_valid && (pass_code == PASS_CODE);
  assign code_bad  = pass_valid && (pass_code != PASS_CODE);
  assign tries_inc = tries_q + 1'b1;

  // Next-state logic; timer restarts on any state change or a wrong code
  always_comb begin
    state_d   = state_q;
    tries_d   = tries_q;
    park_inc  = 1'b0;
    timer_clr = 1'b0;
    case (state_q)
      S_IDLE:
        if (entry) state_d = full ? S_FULL : S_WAIT_PASS;
      S_FULL:
        if (!entry)    state_d = S_IDLE;
        else if (!full) state_d = S_WAIT_PASS;
      S_WAIT_PASS: begin
        if (code_ok) begin
          state_d = S_GRANT;
          tries_d = '0;
        end else if (code_bad) begin
          tries_d = tries_inc;
          if (tries_inc == TRY_W'(MAX_TRIES)) state_d = S_LOCKOUT;
          else                                timer_clr = 1'b1;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          state_d = S_IDLE;
          tries_d = '0;
        end
      end
      S_GRANT:
        if (entry && exit) state_d = S_STOP;
        else if (exit) begin
          state_d  = S_IDLE;
          park_inc = 1'b1;
        end
      S_STOP:
        if (code_ok) state_d = S_GRANT;
      S_LOCKOUT:
        if (timer_q == TMR_W'(LOCK_CYCLES - 1)) begin
          state_d = S_IDLE;
          tries_d = '0;
        end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q || timer_clr)
      timer_d = '0;
    else if (state_q == S_WAIT_PASS || state_q == S_LOCKOUT)
      timer_d = timer_q + 1'b1;
    else
      timer_d = '0;
  end

  // FSM, timer and retry registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      tries_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      tries_q <= tries_d;
    end
  end

  // Free-running blink divider; MSB is high for half of each 2**BLINK_LOG2 period
  always_ff @(posedge clk) begin
    if (!rst) blink_q <= '0;
    else      blink_q <= blink_q + 1'b1;
  end

  // Panel outputs follow the state register by one cycle
  always_ff @(posedge clk) begin
    if (!rst) panel_q <= PANEL_OFF;
    else      panel_q <= state_panel(state_q, blink_q[BLINK_LOG2-1]);
  end

  parking_occ_counter #(
    .CAPACITY(CAPACITY),
    .CNT_W   (CNT_W)
  ) u_occ (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (park_inc),
    .dec_i  (depart),
    .count_o(occupancy),
    .full_o (full)
  );

  assign GREEN     = panel_q.green;
  assign RED       = panel_q.red;
  assign gate_open = panel_q.gate;
  assign HEX_1     = panel_q.hex1;
  assign HEX_2     = panel_q.hex2;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Bench for parking_gate_ctrl: vector table, corner-case sequences and a
// randomized run checked every cycle against a behavioural model.
module tb_parking_gate_ctrl;

  localparam int         CAPACITY    = 8;
  localparam logic [3:0] PASS_CODE   = 4'hA;
  localparam int         TIMEOUT     = 64;
  localparam int         MAX_TRIES   = 3;
  localparam int         LOCK_CYCLES = 256;
  localparam int         BLINK_LOG2  = 3;

  // glyphs written active-high {g..a} and inverted for the active-low display
  localparam logic [6:0] G_BLANK = 7'h7F;
  localparam logic [6:0] G_E = ~7'h79;
  localparam logic [6:0] G_N = ~7'h54;
  localparam logic [6:0] G_F = ~7'h71;
  localparam logic [6:0] G_U = ~7'h3E;
  localparam logic [6:0] G_6 = ~7'h7D;
  localparam logic [6:0] G_0 = ~7'h3F;
  localparam logic [6:0] G_5 = ~7'h6D;
  localparam logic [6:0] G_P = ~7'h73;
  localparam logic [6:0] G_L = ~7'h38;
  localparam logic [6:0] G_O = ~7'h5C;

  logic       clk = 1'b0;
  logic       rst, entry, ext, depart, pass_valid;
  logic [3:0] pass_code;
  logic       GREEN, RED, gate_open, full;
  logic [3:0] occupancy;
  logic [6:0] HEX_1, HEX_2;

  always #5 clk = ~clk;

  parking_gate_ctrl dut (
    .clk(clk), .rst(rst), .entry(entry), .exit(ext), .depart(depart),
    .pass_valid(pass_valid), .pass_code(pass_code),
    .GREEN(GREEN), .RED(RED), .gate_open(gate_open), .occupancy(occupancy),
    .full(full), .HEX_1(HEX_1), .HEX_2(HEX_2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int M_IDLE = 0, M_WAIT = 1, M_FULL = 2, M_GRANT = 3, M_STOP = 4, M_LOCK = 5;
  int m_mode, m_dwell, m_tries, m_occ, m_cyc;
  logic e_green, e_red, e_gate;
  logic [6:0] e_h1, e_h2;

  task automatic model_step();
    bit ok, bad, inc, clr, blink, was_full;
    int nxt;
    if (!rst) begin
      m_mode = M_IDLE; m_dwell = 0; m_tries = 0; m_occ = 0; m_cyc = 0;
      e_green = 0; e_red = 0; e_gate = 0; e_h1 = G_BLANK; e_h2 = G_BLANK;
      return;
    end
    blink = (m_cyc % (1 << BLINK_LOG2)) >= (1 << (BLINK_LOG2 - 1));
    e_green = 0; e_red = 0; e_gate = 0; e_h1 = G_BLANK; e_h2 = G_BLANK;
    case (m_mode)
      M_WAIT:  begin e_red = 1;     e_h1 = G_E; e_h2 = G_N; end
      M_FULL:  begin e_red = 1;     e_h1 = G_F; e_h2 = G_U; end
      M_GRANT: begin e_green = blink; e_gate = 1; e_h1 = G_6; e_h2 = G_0; end
      M_STOP:  begin e_red = blink; e_gate = 1; e_h1 = G_5; e_h2 = G_P; end
      M_LOCK:  begin e_red = blink; e_h1 = G_L; e_h2 = G_O; end
      default: ;
    endcase
    ok  = pass_valid && pass_code == PASS_CODE;
    bad = pass_valid && pass_code != PASS_CODE;
    was_full = (m_occ == CAPACITY);
    inc = 0; clr = 0; nxt = m_mode;
    case (m_mode)
      M_IDLE:  if (entry) nxt = was_full ? M_FULL : M_WAIT;
      M_FULL:  if (!entry) nxt = M_IDLE; else if (!was_full) nxt = M_WAIT;
      M_WAIT:
        if (ok) begin nxt = M_GRANT; m_tries = 0; end
        else if (bad) begin
          m_tries++;
          if (m_tries == MAX_TRIES) nxt = M_LOCK; else clr = 1;
        end else if (m_dwell == TIMEOUT - 1) begin nxt = M_IDLE; m_tries = 0; end
      M_GRANT: if (entry && ext) nxt = M_STOP; else if (ext) begin nxt = M_IDLE; inc = 1; end
      M_STOP:  if (ok) nxt = M_GRANT;
      M_LOCK:  if (m_dwell == LOCK_CYCLES - 1) begin nxt = M_IDLE; m_tries = 0; end
      default: nxt = M_IDLE;
    endcase
    if (inc && !depart && m_occ < CAPACITY) m_occ++;
    else if (depart && !inc && m_occ > 0) m_occ--;
    m_dwell = (nxt != m_mode || clr) ? 0 : m_dwell + 1;
    m_mode = nxt;
    m_cyc++;
  endtask

  // one clock: model follows the DUT edge, outputs compared on the falling edge
  task automatic tick();
    logic [3:0] eocc;
    @(posedge clk);
    model_step();
    @(negedge clk);
    eocc = 4'(m_occ);
    check("model_outputs",
          {GREEN, RED, gate_open, HEX_1, HEX_2, occupancy, full},
          {e_green, e_red, e_gate, e_h1, e_h2, eocc, (m_occ == CAPACITY)});
  endtask

  task automatic drive(input logic e, input logic x, input logic d,
                       input logic v, input logic [3:0] c);
    entry = e; ext = x; depart = d; pass_valid = v; pass_code = c;
  endtask

  task automatic park();
    drive(1, 0, 0, 0, 4'h0); tick();
    drive(1, 0, 0, 1, PASS_CODE); tick();
    drive(0, 1, 0, 0, 4'h0); tick();
    drive(0, 0, 0, 0, 4'h0); tick();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic en, ex, dp, pv;
    logic [3:0] code;
    logic gate;
    logic [6:0] h1, h2;
    int occ;
  } vec_t;

  function automatic vec_t mk(input logic en, ex, dp, pv, input logic [3:0] code,
                              input logic gate, input logic [6:0] h1, h2, input int occ);
    vec_t v;
    v.en = en; v.ex = ex; v.dp = dp; v.pv = pv; v.code = code;
    v.gate = gate; v.h1 = h1; v.h2 = h2; v.occ = occ;
    return v;
  endfunction

  vec_t tbl[13];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, highs;
    tbl[0]  = mk(1,0,0,0,4'h0, 0, G_BLANK, G_BLANK, 0);
    tbl[1]  = mk(1,0,0,0,4'h0, 0, G_E, G_N, 0);
    tbl[2]  = mk(1,0,0,1,PASS_CODE, 0, G_E, G_N, 0);
    tbl[3]  = mk(1,0,0,0,4'h0, 1, G_6, G_0, 0);
    tbl[4]  = mk(0,1,0,0,4'h0, 1, G_6, G_0, 1);
    tbl[5]  = mk(0,0,0,0,4'h0, 0, G_BLANK, G_BLANK, 1);
    tbl[6]  = mk(0,0,1,0,4'h0, 0, G_BLANK, G_BLANK, 0);
    tbl[7]  = mk(0,0,1,0,4'h0, 0, G_BLANK, G_BLANK, 0);
    tbl[8]  = mk(1,0,0,1,4'h5, 0, G_BLANK, G_BLANK, 0);
    tbl[9]  = mk(1,0,0,1,4'h3, 0, G_E, G_N, 0);
    tbl[10] = mk(1,0,0,1,4'h3, 0, G_E, G_N, 0);
    tbl[11] = mk(1,0,0,1,4'h3, 0, G_E, G_N, 0);
    tbl[12] = mk(0,0,0,1,PASS_CODE, 0, G_L, G_O, 0);

    // reset state
    rst = 0; drive(0, 0, 0, 0, 4'h0);
    tick(); tick();
    check("reset_leds_gate", {GREEN, RED, gate_open}, 3'b000);
    check("reset_hex", {HEX_1, HEX_2}, {G_BLANK, G_BLANK});
    check("reset_occ_full", {occupancy, full}, {4'd0, 1'b0});
    rst = 1;

    foreach (tbl[i]) begin
      drive(tbl[i].en, tbl[i].ex, tbl[i].dp, tbl[i].pv, tbl[i].code);
      tick();
      check($sformatf("tbl%0d_gate", i), gate_open, tbl[i].gate);
      check($sformatf("tbl%0d_hex", i), {HEX_1, HEX_2}, {tbl[i].h1, tbl[i].h2});
      check($sformatf("tbl%0d_occ", i), occupancy, 4'(tbl[i].occ));
    end

    // lockout duration, correct code ignored at its start
    cnt = 1;
    for (int g = 0; g < 400; g++) begin
      drive(0, 0, 0, (cnt < 10), PASS_CODE);
      tick();
      if (HEX_1 == G_L) cnt++; else break;
    end
    check("lockout_cycles", cnt, LOCK_CYCLES);
    check("lockout_exit_blank", {HEX_1, HEX_2}, {G_BLANK, G_BLANK});

    // tries cleared after lockout: two wrong codes must not lock again
    drive(1, 0, 0, 0, 4'h0); tick();
    drive(1, 0, 0, 1, 4'h3); tick();
    drive(1, 0, 0, 1, 4'h3); tick();
    drive(1, 0, 0, 1, PASS_CODE); tick();
    drive(1, 0, 0, 0, 4'h0); tick();
    check("tries_cleared_grant", HEX_1, G_6);

    // tailgate -> STOP, blinking red, correct code back to GRANT
    drive(1, 1, 0, 0, 4'h0); tick();
    drive(0, 0, 0, 0, 4'h0); tick();
    check("stop_glyphs", {HEX_1, HEX_2, gate_open, GREEN}, {G_5, G_P, 1'b1, 1'b0});
    highs = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (RED) highs++;
    end
    check("stop_red_duty", highs, 8);
    drive(1, 0, 0, 1, PASS_CODE); tick();
    drive(0, 0, 0, 0, 4'h0); tick();
    check("stop_to_grant", {HEX_1, HEX_2}, {G_6, G_0});
    drive(0, 1, 0, 0, 4'h0); tick();
    drive(0, 0, 0, 0, 4'h0); tick();
    check("occ_after_stop_park", occupancy, 4'd1);

    // entry held with no code: exactly TIMEOUT cycles waiting
    cnt = 0;
    for (int g = 0; g < 200; g++) begin
      drive(1, 0, 0, 0, 4'h0);
      tick();
      if (HEX_1 == G_E) cnt++;
      else if (cnt > 0) break;
    end
    check("timeout_cycles", cnt, TIMEOUT);

    park(); park(); park(); park();
    check("occ_five", occupancy, 4'd5);

    // park and depart in the same cycle leave occupancy unchanged
    drive(1, 0, 0, 0, 4'h0); tick();
    drive(1, 0, 0, 1, PASS_CODE); tick();
    drive(0, 1, 1, 0, 4'h0); tick();
    check("exit_and_depart", occupancy, 4'd5);
    drive(0, 0, 0, 0, 4'h0); tick();

    park(); park(); park();
    check("filled", {occupancy, full}, {4'd8, 1'b1});
    drive(1, 0, 0, 0, 4'h0); tick(); tick();
    check("full_glyphs", {HEX_1, HEX_2, RED}, {G_F, G_U, 1'b1});
    drive(1, 0, 1, 0, 4'h0); tick();
    drive(1, 0, 0, 0, 4'h0); tick();
    check("depart_frees_slot", {occupancy, full}, {4'd7, 1'b0});
    tick();
    check("full_to_wait", {HEX_1, HEX_2}, {G_E, G_N});

    // reset in the middle of GRANT
    drive(1, 0, 0, 1, PASS_CODE); tick();
    drive(1, 0, 0, 0, 4'h0); tick();
    check("grant_before_reset", gate_open, 1'b1);
    rst = 0; tick();
    check("midreset_outputs", {GREEN, RED, gate_open, HEX_1, HEX_2},
          {3'b000, G_BLANK, G_BLANK});
    check("midreset_occ", {occupancy, full}, {4'd0, 1'b0});
    rst = 1;

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 499) != 0);
      drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 1) != 0) ? PASS_CODE : 4'($urandom_range(0, 15)));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
